core_ctrl_fsm: RTL and testbench

- Multi-cycle control sequencer for the PhilosophyV RV32I core.
- Steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB.
- Drives the instruction decoder's controlOverride, the datapath mux selects, register-file and PC write enables, and the instruction/data memory request handshakes.
- Keeps a retired-instruction counter.

---
 rtl/core_ctrl_fsm_pkg.sv | 48 ++++
 rtl/core_ctrl_fsm_branch_resolve.sv | 25 ++
 rtl/core_ctrl_fsm.sv | 158 +++++++++++++++
 tb/tb_core_ctrl_fsm.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_fsm_pkg.sv
// Shared opcode, funct3, state and mux-select encodings for the
// PhilosophyV multi-cycle control sequencer.
package core_ctrl_fsm_pkg;

  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
  localparam logic [6:0] OP_ALU_REG = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] ST_FETCH   = 3'd0;
  localparam logic [2:0] ST_DECODE  = 3'd1;
  localparam logic [2:0] ST_EXECUTE = 3'd2;
  localparam logic [2:0] ST_MEM     = 3'd3;
  localparam logic [2:0] ST_WB      = 3'd4;
  localparam logic [2:0] ST_HALT    = 3'd5;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] PC_PLUS4   = 2'b00;
  localparam logic [1:0] PC_ALU     = 2'b01;
  localparam logic [1:0] PC_ALU_ALN = 2'b10;

  function automatic logic is_legal(input logic [6:0] op);
    logic ok;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_BRANCH, OP_LOAD, OP_STORE,
      OP_ALU_IMM, OP_ALU_REG: ok = 1'b1;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/core_ctrl_fsm_branch_resolve.sv
// Branch condition resolver: funct3 plus comparator flags to taken.
module branch_resolve
  import core_ctrl_fsm_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       cmp_eq,
  input  logic       cmp_lt,
  input  logic       cmp_ltu,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    unique case (funct3)
      F3_BEQ:  taken = cmp_eq;
      F3_BNE:  taken = !cmp_eq;
      F3_BLT:  taken = cmp_lt;
      F3_BGE:  taken = !cmp_lt;
      F3_BLTU: taken = cmp_ltu;
      F3_BGEU: taken = !cmp_ltu;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for the
// PhilosophyV RV32I core, with a retired-instruction counter.
module core_ctrl_fsm
  import core_ctrl_fsm_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic         cmp_eq,
  input  logic         cmp_lt,
  input  logic         cmp_ltu,
  output logic         imem_req,
  input  logic         imem_ready,
  output logic         dmem_req,
  output logic         dmem_we,
  input  logic         dmem_ready,
  output logic         ir_load,
  output logic         control_override,
  output logic         alu_a_sel,
  output logic         alu_b_sel,
  output logic [1:0]   wb_sel,
  output logic [1:0]   pc_sel,
  output logic         pc_write,
  output logic         reg_write,
  output logic         retire,
  output logic         illegal_instr,
  output logic [N-1:0] instret
);

  logic [2:0]   state;
  logic [2:0]   state_nxt;
  logic [N-1:0] cnt;
  logic         taken;

  logic is_alu;
  logic is_load;
  logic is_store;
  logic is_jal;
  logic is_jalr;
  logic is_branch;
  logic use_pc_a;
  logic use_imm_b;

  assign is_alu    = (opcode == OP_ALU_REG) || (opcode == OP_ALU_IMM);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_branch = (opcode == OP_BRANCH);
  assign use_pc_a  = (opcode == OP_AUIPC) || is_jal || is_branch;
  assign use_imm_b = (opcode != OP_ALU_REG);

  branch_resolve u_branch_resolve (
    .funct3  (funct3),
    .cmp_eq  (cmp_eq),
    .cmp_lt  (cmp_lt),
    .cmp_ltu (cmp_ltu),
    .taken   (taken)
  );

  // No ALU output register: operand selects stay valid from EXECUTE on.
  always_comb begin
    state_nxt        = state;
    imem_req         = 1'b0;
    dmem_req         = 1'b0;
    dmem_we          = 1'b0;
    ir_load          = 1'b0;
    control_override = 1'b0;
    alu_a_sel        = 1'b0;
    alu_b_sel        = 1'b0;
    wb_sel           = WB_ALU;
    pc_sel           = PC_PLUS4;
    pc_write         = 1'b0;
    reg_write        = 1'b0;
    retire           = 1'b0;
    illegal_instr    = 1'b0;
    if (!rst) begin
      case (state)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_load   = 1'b1;
            state_nxt = ST_DECODE;
          end
        end
        ST_DECODE: begin
          state_nxt = is_legal(opcode) ? ST_EXECUTE : ST_HALT;
        end
        ST_EXECUTE: begin
          control_override = !is_alu;
          alu_a_sel        = use_pc_a;
          alu_b_sel        = use_imm_b;
          if (is_jal)  pc_sel = PC_ALU;
          if (is_jalr) pc_sel = PC_ALU_ALN;
          if (is_branch) begin
            pc_write  = 1'b1;
            pc_sel    = taken ? PC_ALU : PC_PLUS4;
            retire    = 1'b1;
            state_nxt = ST_FETCH;
          end else if (is_load || is_store) begin
            state_nxt = ST_MEM;
          end else begin
            state_nxt = ST_WB;
          end
        end
        ST_MEM: begin
          control_override = 1'b1;
          alu_a_sel        = use_pc_a;
          alu_b_sel        = use_imm_b;
          dmem_req         = 1'b1;
          dmem_we          = is_store;
          if (dmem_ready) begin
            if (is_store) begin
              pc_write  = 1'b1;
              retire    = 1'b1;
              state_nxt = ST_FETCH;
            end else begin
              state_nxt = ST_WB;
            end
          end
        end
        ST_WB: begin
          control_override = !is_alu;
          alu_a_sel        = use_pc_a;
          alu_b_sel        = use_imm_b;
          reg_write        = 1'b1;
          retire           = 1'b1;
          pc_write         = 1'b1;
          if (is_load)             wb_sel = WB_MEM;
          else if (is_jal|is_jalr) wb_sel = WB_PC4;
          if (is_jal)  pc_sel = PC_ALU;
          if (is_jalr) pc_sel = PC_ALU_ALN;
          state_nxt = ST_FETCH;
        end
        ST_HALT: begin
          illegal_instr = 1'b1;
        end
        default: state_nxt = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (retire) cnt <= cnt + 1'b1;
    end
  end

  assign instret = rst ? '0 : cnt;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Scoreboard bench for core_ctrl_fsm: directed instructions, memory
// responders with programmable wait, and a retire-driven monitor.
module tb_core_ctrl_fsm;
  import core_ctrl_fsm_pkg::*;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [6:0]   opcode = '0;
  logic [2:0]   funct3 = '0;
  logic         cmp_eq = 1'b0;
  logic         cmp_lt = 1'b0;
  logic         cmp_ltu = 1'b0;
  logic         imem_req;
  logic         imem_ready = 1'b0;
  logic         dmem_req;
  logic         dmem_we;
  logic         dmem_ready = 1'b0;
  logic         ir_load;
  logic         control_override;
  logic         alu_a_sel;
  logic         alu_b_sel;
  logic [1:0]   wb_sel;
  logic [1:0]   pc_sel;
  logic         pc_write;
  logic         reg_write;
  logic         retire;
  logic         illegal_instr;
  logic [N-1:0] instret;

  core_ctrl_fsm #(.N(N)) dut (
    .clk              (clk),
    .rst              (rst),
    .opcode           (opcode),
    .funct3           (funct3),
    .cmp_eq           (cmp_eq),
    .cmp_lt           (cmp_lt),
    .cmp_ltu          (cmp_ltu),
    .imem_req         (imem_req),
    .imem_ready       (imem_ready),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_ready       (dmem_ready),
    .ir_load          (ir_load),
    .control_override (control_override),
    .alu_a_sel        (alu_a_sel),
    .alu_b_sel        (alu_b_sel),
    .wb_sel           (wb_sel),
    .pc_sel           (pc_sel),
    .pc_write         (pc_write),
    .reg_write        (reg_write),
    .retire           (retire),
    .illegal_instr    (illegal_instr),
    .instret          (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    int          ic;
    int          dc;
    logic        we;
    logic        co;
    logic        rw;
    logic [1:0]  wb;
    logic [1:0]  pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  int errors  = 0;
  int checks  = 0;
  int retired = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Instruction register model and the word the next fetch returns
  logic [6:0] nxt_op = '0;
  logic [2:0] nxt_f3 = '0;
  always @(posedge clk)
    if (ir_load) begin
      opcode <= nxt_op;
      funct3 <= nxt_f3;
    end

  int imem_wait = 0;
  int dmem_wait = 0;
  int icnt = 0;
  int dcnt = 0;

  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      imem_ready = 1'b0; icnt = 0;
      dmem_ready = 1'b0; dcnt = 0;
    end else begin
      if (imem_req && !imem_ready) begin
        if (icnt >= imem_wait) imem_ready = 1'b1;
        else icnt++;
      end else begin
        imem_ready = 1'b0; icnt = 0;
      end
      if (dmem_req && !dmem_ready) begin
        if (dcnt >= dmem_wait) dmem_ready = 1'b1;
        else dcnt++;
      end else begin
        dmem_ready = 1'b0; dcnt = 0;
      end
    end
  end

  int   m_cyc = 0;
  int   m_ic  = 0;
  int   m_dc  = 0;
  int   m_irl = 0;
  logic m_we  = 1'b0;
  logic m_co  = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      m_cyc = 0; m_ic = 0; m_dc = 0; m_irl = 0;
      m_we = 1'b0; m_co = 1'b0;
    end else begin
      m_cyc++;
      if (imem_req) m_ic++;
      if (dmem_req) m_dc++;
      if (ir_load) m_irl++;
      if (dmem_req && dmem_we) m_we = 1'b1;
      if (control_override) m_co = 1'b1;
      if (retire) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_retire: got retire expected none");
        end else begin
          mon_e = sbq.pop_front();
          chk("latency", m_cyc, mon_e.lat);
          chk("imem_req_cycles", m_ic, mon_e.ic);
          chk("dmem_req_cycles", m_dc, mon_e.dc);
          chk("ir_load_count", m_irl, 1);
          chk("dmem_we", {31'b0, m_we}, {31'b0, mon_e.we});
          chk("ctrl_override", {31'b0, m_co}, {31'b0, mon_e.co});
          chk("reg_write", {31'b0, reg_write}, {31'b0, mon_e.rw});
          chk("wb_sel", {30'b0, wb_sel}, {30'b0, mon_e.wb});
          chk("pc_sel", {30'b0, pc_sel}, {30'b0, mon_e.pc});
          chk("pc_write", {31'b0, pc_write}, 1);
          chk("instret", instret, mon_e.inst);
        end
        retired++;
        m_cyc = 0; m_ic = 0; m_dc = 0; m_irl = 0;
        m_we = 1'b0; m_co = 1'b0;
      end
    end
  end

  task automatic issue(
    input logic [6:0] op, input logic [2:0] f3,
    input logic eq, input logic lt, input logic ltu,
    input int iw, input int dw,
    input int lat, input int ic, input int dc,
    input logic we, input logic co, input logic rw,
    input logic [1:0] wb, input logic [1:0] pc,
    input logic [31:0] inst);
    exp_t e;
    int   start;
    nxt_op = op; nxt_f3 = f3;
    cmp_eq = eq; cmp_lt = lt; cmp_ltu = ltu;
    imem_wait = iw; dmem_wait = dw;
    e.lat = lat; e.ic = ic; e.dc = dc; e.we = we; e.co = co;
    e.rw = rw; e.wb = wb; e.pc = pc; e.inst = inst;
    sbq.push_back(e);
    start = retired;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      if (retired != start) break;
    end
    if (retired == start) begin
      checks++; errors++;
      $display("FAIL retire_timeout: got none expected retire op=%b", op);
      sbq.delete();
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_imem_req", {31'b0, imem_req}, 0);
    chk("rst_instret", instret, 0);
    chk("rst_illegal", {31'b0, illegal_instr}, 0);
    chk("rst_retire", {31'b0, retire}, 0);
    rst = 1'b0;

    //    op          f3      eq lt lu iw dw lat ic dc we co rw wb     pc     inst
    issue(OP_ALU_REG, 3'b000, 0, 0, 0, 3, 0, 7,  4, 0, 0, 0, 1, WB_ALU, PC_PLUS4,   0);
    issue(OP_LOAD,    3'b010, 0, 0, 0, 0, 2, 7,  1, 3, 0, 1, 1, WB_MEM, PC_PLUS4,   1);
    issue(OP_BRANCH,  F3_BEQ, 1, 0, 0, 0, 0, 3,  1, 0, 0, 1, 0, WB_ALU, PC_ALU,     2);
    issue(OP_BRANCH,  F3_BNE, 1, 0, 0, 0, 0, 3,  1, 0, 0, 1, 0, WB_ALU, PC_PLUS4,   3);
    issue(OP_JALR,    3'b000, 0, 0, 0, 0, 0, 4,  1, 0, 0, 1, 1, WB_PC4, PC_ALU_ALN, 4);
    issue(OP_STORE,   3'b010, 0, 0, 0, 0, 0, 4,  1, 1, 1, 1, 0, WB_ALU, PC_PLUS4,   5);
    issue(OP_BRANCH,  F3_BLTU,0, 0, 1, 0, 0, 3,  1, 0, 0, 1, 0, WB_ALU, PC_ALU,     6);
    issue(OP_BRANCH,  F3_BGE, 0, 1, 0, 0, 0, 3,  1, 0, 0, 1, 0, WB_ALU, PC_PLUS4,   7);
    issue(OP_JAL,     3'b000, 0, 0, 0, 0, 0, 4,  1, 0, 0, 1, 1, WB_PC4, PC_ALU,     8);
    issue(OP_LUI,     3'b000, 0, 0, 0, 0, 0, 4,  1, 0, 0, 1, 1, WB_ALU, PC_PLUS4,   9);
    issue(OP_AUIPC,   3'b000, 0, 0, 0, 1, 0, 5,  2, 0, 0, 1, 1, WB_ALU, PC_PLUS4,  10);
    issue(OP_ALU_IMM, 3'b000, 0, 0, 0, 0, 0, 4,  1, 0, 0, 0, 1, WB_ALU, PC_PLUS4,  11);
    issue(OP_BRANCH,  3'b010, 1, 1, 1, 0, 0, 3,  1, 0, 0, 1, 0, WB_ALU, PC_PLUS4,  12);
    issue(OP_BRANCH,  F3_BGEU,0, 0, 0, 0, 0, 3,  1, 0, 0, 1, 0, WB_ALU, PC_ALU,    13);
    issue(OP_BRANCH,  F3_BLT, 0, 1, 0, 0, 0, 3,  1, 0, 0, 1, 0, WB_ALU, PC_ALU,    14);
    issue(OP_STORE,   3'b010, 0, 0, 0, 0, 1, 5,  1, 2, 1, 1, 0, WB_ALU, PC_PLUS4,  15);

    // Illegal opcode: halt until reset
    nxt_op = 7'b1111111; imem_wait = 0; dmem_wait = 0;
    @(posedge clk); #1;
    chk("instret_16", instret, 16);
    for (int c = 0; c < 10 && !illegal_instr; c++) begin
      @(negedge clk); #1;
    end
    chk("halt_entered", {31'b0, illegal_instr}, 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      chk("halt_illegal", {31'b0, illegal_instr}, 1);
      chk("halt_imem_req", {31'b0, imem_req}, 0);
    end
    rst = 1'b1;
    nxt_op = OP_LOAD; dmem_wait = 50;
    @(negedge clk); #1;
    chk("halt_rst_illegal", {31'b0, illegal_instr}, 0);
    chk("halt_rst_instret", instret, 0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("post_halt_fetch", {31'b0, imem_req}, 1);
    chk("post_halt_illegal", {31'b0, illegal_instr}, 0);

    // Reset while a load waits on dmem
    for (int c = 0; c < 20 && !dmem_req; c++) begin
      @(negedge clk); #1;
    end
    chk("mem_wait_reached", {31'b0, dmem_req}, 1);
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rst_mem_dmem_req", {31'b0, dmem_req}, 0);
    chk("rst_mem_instret", instret, 0);
    nxt_op = OP_ALU_REG; dmem_wait = 0;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_mem_fetch", {31'b0, imem_req}, 1);
    chk("rst_mem_no_dmem", {31'b0, dmem_req}, 0);
    issue(OP_ALU_REG, 3'b000, 0, 0, 0, 0, 0, 4,  1, 0, 0, 0, 1, WB_ALU, PC_PLUS4,   0);
    @(posedge clk); #1;
    chk("final_instret", instret, 1);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
